alu_result_buffer: RTL and testbench



---
 rtl/alu_result_buffer.sv | 113 +++++++++++
 tb/tb_alu_result_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Registered FIFO between ALU and writeback: 1-cycle push-to-visible, in_ready from registered count only.
// Flags commit on push; ALU_RESULT_BUF_STICKY_M_EN adds a sticky signed-overflow bit (sticky_m/clr_sticky).
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_F,
  input  logic                     in_cout,
  input  logic                     in_z,
  input  logic                     in_n,
  input  logic                     in_m,
  input  logic                     in_setf,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_F,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               flags,
`ifdef ALU_RESULT_BUF_STICKY_M_EN
  output logic                     sticky_m,
  input  logic                     clr_sticky,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] f_mem_q   [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    flags_q, flags_d;
  logic          push, pop;

  always_comb begin
    in_ready  = (count_q != FULL);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Flags track push order so the next ALU op sees them before writeback drains.
    if (push && in_setf) flags_d = {in_n, in_z, in_cout, in_m};

    out_F   = out_valid ? f_mem_q[rd_ptr_q]   : '0;
    out_tag = out_valid ? tag_mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_mem_q[wr_ptr_q]   <= in_F;
      tag_mem_q[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  assign flags = flags_q;
  assign count = count_q;

`ifdef ALU_RESULT_BUF_STICKY_M_EN
  logic sticky_q;

  // A setting push wins over a same-cycle clear; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)                sticky_q <= 1'b0;
    else if (push && in_m)  sticky_q <= 1'b1;
    else if (clr_sticky)    sticky_q <= 1'b0;
  end

  assign sticky_m = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_alu_result_buffer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, in_valid, in_ready;
  logic [WIDTH-1:0] in_F;
  logic             in_cout, in_z, in_n, in_m, in_setf;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_F;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;
  logic [2:0]       count;
  logic             sticky_m, clr_sticky;

  alu_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_F(in_F),
    .in_cout(in_cout), .in_z(in_z), .in_n(in_n), .in_m(in_m),
    .in_setf(in_setf), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_F(out_F), .out_tag(out_tag), .flags(flags),
`ifdef ALU_RESULT_BUF_STICKY_M_EN
    .sticky_m(sticky_m), .clr_sticky(clr_sticky),
`endif
    .count(count)
  );

`ifndef ALU_RESULT_BUF_STICKY_M_EN
  assign sticky_m = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] f;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_flags;
  logic       m_sticky;
  int         checks = 0;
  int         errors = 0;

  task automatic idle();
    flush = 0; in_valid = 0; in_F = '0; in_tag = '0;
    in_cout = 0; in_z = 0; in_n = 0; in_m = 0; in_setf = 0;
    clr_sticky = 0;
  endtask

  // Advance one clock edge and update the reference model from the inputs seen at that edge.
  task automatic tick();
    bit m_push, m_pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_flags  = 4'b0000;
      m_sticky = 1'b0;
    end else begin
      m_push = in_valid && (q.size() < DEPTH) && !flush;
      m_pop  = (q.size() > 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back('{in_F, in_tag});
      end
      if (m_push && in_setf) m_flags = {in_n, in_z, in_cout, in_m};
      if (m_push && in_m) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); out_ready = 0; rst = 1;
    tick(); tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    checks++; if (out_F !== '0) begin errors++; $display("FAIL reset_out_F: got %h expected 0", out_F); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    rst = 0;
  endtask

  task automatic test_fill_stall();
    logic [TAG_W-1:0] tg [4];
    idle(); out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_F = WIDTH'(i + 1); tg[i] = TAG_W'($urandom); in_tag = tg[i];
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    in_valid = 1; in_F = 32'd5; in_tag = 5'd31; out_ready = 1;
    checks++; if (out_F !== 32'd1) begin errors++; $display("FAIL fill_head0: got %0d expected 1", out_F); end
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_fifth_dropped: got count %0d expected 3", count); end
    in_valid = 0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_F !== WIDTH'(i + 1) || out_tag !== tg[i]) begin
        errors++; $display("FAIL fill_pop%0d: got F=%0d tag=%0d expected F=%0d tag=%0d", i, out_F, out_tag, i + 1, tg[i]);
      end
      tick();
    end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_F !== '0) begin
      errors++; $display("FAIL fill_drained: got count=%0d valid=%b F=%h expected 0/0/0", count, out_valid, out_F);
    end
  endtask

  task automatic test_streaming();
    idle(); out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_F = $urandom; in_tag = TAG_W'($urandom);
      tick();
      checks++; if (count !== 3'd1 || out_valid !== 1'b1 || out_F !== in_F || out_tag !== in_tag) begin
        errors++; $display("FAIL stream_%0d: got count=%0d F=%h tag=%0d expected 1/%h/%0d", i, count, out_F, out_tag, in_F, in_tag);
      end
    end
    in_valid = 0; tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flags();
    logic n, z, c;
    idle(); out_ready = 1;
    in_valid = 1; in_F = 32'h0; in_z = 1; in_setf = 1;
    tick();
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL flags_z: got %b expected 0100", flags); end
    idle(); in_valid = 1; in_F = 32'h8000_0000; in_n = 1; in_cout = 1; in_setf = 0;
    tick();
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL flags_nosetf: got %b expected 0100", flags); end
    n = 1'($urandom); z = 1'($urandom); c = 1'($urandom);
    idle(); in_valid = 1; in_F = $urandom; in_n = n; in_z = z; in_cout = c; in_m = 1; in_setf = 1;
    tick();
    checks++; if (flags !== {n, z, c, 1'b1}) begin errors++; $display("FAIL flags_m: got %b expected %b", flags, {n, z, c, 1'b1}); end
    idle(); tick(); tick();
  endtask

  task automatic test_flush();
    logic [3:0]       f0;
    logic [WIDTH-1:0] v;
    idle(); out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_F = $urandom; in_tag = TAG_W'($urandom); tick();
    end
    f0 = flags;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    idle(); flush = 1; in_valid = 1; in_setf = 1; in_z = 1; in_F = 32'h1234; out_ready = 1;
    tick();
    idle();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty: got count=%0d valid=%b ready=%b expected 0/0/1", count, out_valid, in_ready);
    end
    checks++; if (flags !== f0) begin errors++; $display("FAIL flush_flags: got %b expected %b", flags, f0); end
    v = $urandom; in_valid = 1; in_F = v; out_ready = 0; tick(); idle();
    checks++; if (out_F !== v || count !== 3'd1) begin errors++; $display("FAIL flush_repush: got F=%h count=%0d expected %h/1", out_F, count, v); end
    out_ready = 1; tick();
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && q.size() == DEPTH)) begin
        in_valid = ($urandom % 4) != 0; in_F = $urandom; in_tag = TAG_W'($urandom);
        in_cout = 1'($urandom); in_z = 1'($urandom); in_n = 1'($urandom);
        in_m = ($urandom % 6) == 0; in_setf = 1'($urandom);
      end
      out_ready  = ($urandom % 3) != 0;
      flush      = ($urandom % 32) == 0;
      clr_sticky = ($urandom % 8) == 0;
      tick();
      checks++; if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH)) begin
        errors++; $display("FAIL rand_%0d_count: got count=%0d valid=%b ready=%b expected count=%0d", i, count, out_valid, in_ready, q.size());
      end
      checks++; if (q.size() != 0 ? (out_F !== q[0].f || out_tag !== q[0].tag) : (out_F !== '0 || out_tag !== '0)) begin
        errors++; $display("FAIL rand_%0d_head: got F=%h tag=%0d expected F=%h", i, out_F, out_tag, q.size() != 0 ? q[0].f : '0);
      end
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL rand_%0d_flags: got %b expected %b", i, flags, m_flags); end
`ifdef ALU_RESULT_BUF_STICKY_M_EN
      checks++; if (sticky_m !== m_sticky) begin errors++; $display("FAIL rand_%0d_sticky: got %b expected %b", i, sticky_m, m_sticky); end
`endif
    end
    idle(); out_ready = 1; tick(); tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    idle(); out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_F = $urandom; in_m = 1; in_n = 1; in_setf = 1; tick();
    end
    rst = 1; tick();
    rst = 0; idle();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_F !== '0) begin
      errors++; $display("FAIL midreset_state: got count=%0d valid=%b ready=%b F=%h expected 0/0/1/0", count, out_valid, in_ready, out_F);
    end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %b expected 0000", flags); end
`ifdef ALU_RESULT_BUF_STICKY_M_EN
    checks++; if (sticky_m !== 1'b0) begin errors++; $display("FAIL midreset_sticky: got %b expected 0", sticky_m); end
`endif
  endtask

`ifdef ALU_RESULT_BUF_STICKY_M_EN
  task automatic test_sticky();
    logic [3:0] f0;
    idle(); out_ready = 1; f0 = flags;
    in_valid = 1; in_F = $urandom; in_m = 1; in_setf = 0; tick(); idle();
    checks++; if (sticky_m !== 1'b1 || flags !== f0) begin errors++; $display("FAIL sticky_set: got %b flags=%b expected 1 flags=%b", sticky_m, flags, f0); end
    flush = 1; tick(); idle();
    checks++; if (sticky_m !== 1'b1) begin errors++; $display("FAIL sticky_flush: got %b expected 1", sticky_m); end
    clr_sticky = 1; tick(); idle();
    checks++; if (sticky_m !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b expected 0", sticky_m); end
    clr_sticky = 1; in_valid = 1; in_m = 1; in_F = $urandom; tick(); idle();
    checks++; if (sticky_m !== 1'b1) begin errors++; $display("FAIL sticky_clr_vs_push: got %b expected 1", sticky_m); end
    tick();
  endtask
`endif

  initial begin
    rst = 1; out_ready = 0; idle();
    q.delete(); m_flags = 4'b0000; m_sticky = 1'b0;
    test_reset();
    test_fill_stall();
    test_streaming();
    test_flags();
    test_flush();
    test_random();
    test_reset_mid();
`ifdef ALU_RESULT_BUF_STICKY_M_EN
    test_sticky();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
